gmii_tx_frame_buffer: RTL and testbench

//  Store-and-forward TX frame buffer between the UDP stack and the GMII/RGMII TX path.

---
 rtl/gmii_tx_frame_buffer.sv | 181 ++++++++++++++++++
 tb/tb_gmii_tx_frame_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_frame_buffer.sv
// Store-and-forward TX frame buffer between the UDP stack and the GMII/RGMII TX path.
// Only whole frames are committed; each is replayed contiguously with speed pacing and an IFG.
module gmii_tx_frame_buffer #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 12,
   parameter int LEN_ADDR_W = 4,
   parameter int IFG_CYCLES = 12,
   parameter int SLOW_DIV   = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_speed1000,
   input  logic [DATA_W-1:0]     i_tx_data,
   input  logic                  i_tx_valid,
   output logic [DATA_W-1:0]     o_tx_data,
   output logic                  o_tx_valid,
   output logic                  o_drop,
   output logic [LEN_ADDR_W:0]   o_frames_queued
);

   localparam int PTR_W     = ADDR_W + 1;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int LEN_DEPTH = 1 << LEN_ADDR_W;
   localparam int IFG_SLOW  = IFG_CYCLES * SLOW_DIV;
   localparam int CNT_W     = $clog2(IFG_SLOW + 1);
   localparam int HOLD_W    = $clog2(SLOW_DIV + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_IFG} state_t;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]    lenMem_q [LEN_DEPTH];
   logic [DATA_W-1:0]   ramQ_q;

   logic                prevValid_q;
   logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]    commitPtr_q, commitPtr_d;
   logic [PTR_W-1:0]    wrLen_q, wrLen_d;
   logic                dropping_q, dropping_d;
   logic                drop_q, drop_d;
   logic [LEN_ADDR_W:0] lenWr_q, lenRd_q;
   logic [LEN_ADDR_W:0] framesQueued_q;

   state_t              state_q;
   logic                spd_q;
   logic [PTR_W-1:0]    rdPtr_q;
   logic [PTR_W-1:0]    remain_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [CNT_W-1:0]    ifgCnt_q;
   logic [DATA_W-1:0]   txData_q;
   logic                txValid_q;

   logic ramFull, lenFull, lenEmpty;
   logic wrEn, push, pop, ramRd;

   // Free space is measured against the read pointer, so bytes of the frame in progress count as used.
   assign ramFull  = (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]) &&
                     (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]);
   assign lenFull  = (lenWr_q[LEN_ADDR_W] != lenRd_q[LEN_ADDR_W]) &&
                     (lenWr_q[LEN_ADDR_W-1:0] == lenRd_q[LEN_ADDR_W-1:0]);
   assign lenEmpty = (lenWr_q == lenRd_q);
   assign pop      = (state_q == S_IDLE) && !lenEmpty;
   assign ramRd    = (state_q == S_LOAD) ||
                     ((state_q == S_SEND) && (hold_q == '0) && (remain_q != '0));

   always_comb begin
      wrPtr_d     = wrPtr_q;
      commitPtr_d = commitPtr_q;
      wrLen_d     = wrLen_q;
      dropping_d  = dropping_q;
      drop_d      = 1'b0;
      wrEn        = 1'b0;
      push        = 1'b0;
      if (i_tx_valid) begin
         if (!dropping_q && !ramFull) begin
            wrEn    = 1'b1;
            wrPtr_d = wrPtr_q + 1'b1;
            wrLen_d = wrLen_q + 1'b1;
         end else begin
            dropping_d = 1'b1;
         end
      end else if (prevValid_q) begin
         if (dropping_q || lenFull) begin
            wrPtr_d = commitPtr_q;
            drop_d  = 1'b1;
         end else begin
            push        = 1'b1;
            commitPtr_d = wrPtr_q;
         end
         wrLen_d    = '0;
         dropping_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prevValid_q    <= 1'b0;
         wrPtr_q        <= '0;
         commitPtr_q    <= '0;
         wrLen_q        <= '0;
         dropping_q     <= 1'b0;
         drop_q         <= 1'b0;
         lenWr_q        <= '0;
         framesQueued_q <= '0;
      end else begin
         prevValid_q <= i_tx_valid;
         wrPtr_q     <= wrPtr_d;
         commitPtr_q <= commitPtr_d;
         wrLen_q     <= wrLen_d;
         dropping_q  <= dropping_d;
         drop_q      <= drop_d;
         if (push) lenWr_q <= lenWr_q + 1'b1;
         if (push && !pop)      framesQueued_q <= framesQueued_q + 1'b1;
         else if (pop && !push) framesQueued_q <= framesQueued_q - 1'b1;
      end
   end

   // Storage arrays carry no reset so they can map onto block RAM.
   always_ff @(posedge i_clk) begin
      if (wrEn)  mem_q[wrPtr_q[ADDR_W-1:0]] <= i_tx_data;
      if (push)  lenMem_q[lenWr_q[LEN_ADDR_W-1:0]] <= wrLen_q;
      if (ramRd) ramQ_q <= mem_q[rdPtr_q[ADDR_W-1:0]];
   end

   // ramQ_q always holds the next byte; the read pointer only advances over bytes of the current frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         spd_q     <= 1'b0;
         rdPtr_q   <= '0;
         lenRd_q   <= '0;
         remain_q  <= '0;
         hold_q    <= '0;
         ifgCnt_q  <= '0;
         txData_q  <= '0;
         txValid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  remain_q <= lenMem_q[lenRd_q[LEN_ADDR_W-1:0]];
                  lenRd_q  <= lenRd_q + 1'b1;
                  spd_q    <= i_speed1000;
                  state_q  <= S_LOAD;
               end
            end
            S_LOAD: begin
               rdPtr_q <= rdPtr_q + 1'b1;
               hold_q  <= '0;
               state_q <= S_SEND;
            end
            S_SEND: begin
               if (hold_q != '0) begin
                  hold_q <= hold_q - 1'b1;
               end else if (remain_q != '0) begin
                  txData_q  <= ramQ_q;
                  txValid_q <= 1'b1;
                  remain_q  <= remain_q - 1'b1;
                  if (remain_q > PTR_W'(1)) rdPtr_q <= rdPtr_q + 1'b1;
                  hold_q    <= spd_q ? '0 : HOLD_W'(SLOW_DIV - 1);
               end else begin
                  txData_q  <= '0;
                  txValid_q <= 1'b0;
                  ifgCnt_q  <= spd_q ? CNT_W'(IFG_CYCLES - 1) : CNT_W'(IFG_SLOW - 1);
                  state_q   <= S_IFG;
               end
            end
            S_IFG: begin
               if (ifgCnt_q == '0) state_q <= S_IDLE;
               else                ifgCnt_q <= ifgCnt_q - 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_tx_data       = txData_q;
   assign o_tx_valid      = txValid_q;
   assign o_drop          = drop_q;
   assign o_frames_queued = framesQueued_q;

endmodule

// File: tb/tb_gmii_tx_frame_buffer.sv
// Scoreboard bench for gmii_tx_frame_buffer: a default-size instance plus a 256-byte
// instance with a long IFG so frames pile up undrained and overflow the data RAM.
module tb_gmii_tx_frame_buffer;

   localparam int IFG_A = 12;
   localparam int IFG_B = 400;
   localparam int DIV   = 2;

   typedef struct {
      int len;
      int hold;
      int base;
      int expStart;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       speed = 1'b1;
   logic [7:0] dataA = '0, dataB = '0;
   logic       validA = 1'b0, validB = 1'b0;
   logic [7:0] outDataA, outDataB;
   logic       outValidA, outValidB, dropA, dropB;
   logic [4:0] fqA, fqB;

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   frame_t qA[$];
   frame_t qB[$];
   bit     busy [2];
   int     drops [2];
   int     expDrops [2];
   int     peak [2];

   gmii_tx_frame_buffer #(
      .DATA_W(8), .ADDR_W(12), .LEN_ADDR_W(4), .IFG_CYCLES(IFG_A), .SLOW_DIV(DIV)
   ) dutA (
      .i_clk(clk), .i_rst(rst), .i_speed1000(speed),
      .i_tx_data(dataA), .i_tx_valid(validA),
      .o_tx_data(outDataA), .o_tx_valid(outValidA), .o_drop(dropA), .o_frames_queued(fqA)
   );

   gmii_tx_frame_buffer #(
      .DATA_W(8), .ADDR_W(8), .LEN_ADDR_W(4), .IFG_CYCLES(IFG_B), .SLOW_DIV(DIV)
   ) dutB (
      .i_clk(clk), .i_rst(rst), .i_speed1000(speed),
      .i_tx_data(dataB), .i_tx_valid(validB),
      .o_tx_data(outDataB), .o_tx_valid(outValidB), .o_drop(dropB), .o_frames_queued(fqB)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pat(input int base, input int i);
      logic [31:0] t;
      t = base * 7 + i * 13 + (i >> 4);
      return t[7:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic driveBytes(input int which, input int len, input int base);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         if (which == 0) begin validA = 1'b1; dataA = pat(base, i); end
         else            begin validB = 1'b1; dataB = pat(base, i); end
      end
   endtask

   // The commit edge is the one after valid drops, so output should rise three edges later.
   task automatic applyStimulus(input int which, input int len, input int base,
                                input bit expectDrop, input bit checkLat);
      frame_t f;
      driveBytes(which, len, base);
      @(posedge clk); #1;
      if (which == 0) begin validA = 1'b0; dataA = '0; end
      else            begin validB = 1'b0; dataB = '0; end
      if (expectDrop) begin
         expDrops[which]++;
      end else begin
         f.len      = len;
         f.hold     = speed ? 1 : DIV;
         f.base     = base;
         f.expStart = checkLat ? cyc + 4 : -1;
         if (which == 0) qA.push_back(f);
         else            qB.push_back(f);
      end
   endtask

   task automatic doReset(input int cycles);
      @(posedge clk); #1;
      rst = 1'b1;
      validA = 1'b0; dataA = '0;
      validB = 1'b0; dataB = '0;
      qA.delete();
      qB.delete();
      repeat (cycles) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic waitDrain(input int which, input int budget, input int ifg);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (n < budget && !done) begin
         @(posedge clk);
         n++;
         if (which == 0) done = (qA.size() == 0) && !busy[0] && (fqA == 0);
         else            done = (qB.size() == 0) && !busy[1] && (fqB == 0);
      end
      checkOutput("drain_done", done, 1);
      repeat (ifg * DIV + 5) @(posedge clk);
   endtask

   task automatic monitor(input int which, input int ifg);
      frame_t     cur;
      bit         gapValid, queuedAtEnd, rstPrev;
      int         run, gap, prevHold, idx, qsize;
      logic       v, dr;
      logic [7:0] d;
      logic [4:0] fq;
      gapValid = 1'b0; queuedAtEnd = 1'b0; rstPrev = 1'b0;
      run = 0; gap = 0; prevHold = 1;
      cur = '{len: 0, hold: 1, base: 0, expStart: -1};
      forever begin
         @(negedge clk);
         if (which == 0) begin v = outValidA; d = outDataA; dr = dropA; fq = fqA; end
         else            begin v = outValidB; d = outDataB; dr = dropB; fq = fqB; end
         if (rstPrev) begin
            checkOutput("rst_valid", v, 0);
            checkOutput("rst_data", d, 0);
            checkOutput("rst_drop", dr, 0);
            checkOutput("rst_queued", fq, 0);
         end
         rstPrev = rst;
         if (rst) begin
            busy[which] = 1'b0;
            gapValid = 1'b0;
         end else begin
            if (int'(fq) > peak[which]) peak[which] = int'(fq);
            if (dr) drops[which]++;
            if (v && !busy[which]) begin
               qsize = (which == 0) ? qA.size() : qB.size();
               busy[which] = 1'b1;
               run = 0;
               if (qsize == 0) begin
                  checkOutput("unexpected_frame", 1, 0);
                  cur = '{len: 0, hold: 1, base: 0, expStart: -1};
               end else begin
                  if (which == 0) cur = qA.pop_front();
                  else            cur = qB.pop_front();
                  if (cur.expStart >= 0) checkOutput("latency", cyc, cur.expStart);
                  if (gapValid && queuedAtEnd) checkOutput("ifg_gap", gap, ifg * prevHold + 3);
                  else if (gapValid)           checkOutput("ifg_min", gap >= ifg * prevHold, 1);
               end
            end
            if (v) begin
               idx = run / cur.hold;
               if (idx < cur.len) checkOutput("data", d, pat(cur.base, idx));
               run++;
            end else begin
               checkOutput("idle_data", d, 0);
               if (busy[which]) begin
                  checkOutput("frame_len", run, cur.len * cur.hold);
                  busy[which] = 1'b0;
                  gap = 1;
                  gapValid = 1'b1;
                  queuedAtEnd = (fq != 0);
                  prevHold = cur.hold;
               end else begin
                  gap++;
               end
            end
         end
      end
   endtask

   initial begin
      fork
         monitor(0, IFG_A);
         monitor(1, IFG_B);
      join_none
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Gigabit: two 64-byte frames, second queued so the IFG is measured exactly.
      speed = 1'b1;
      applyStimulus(0, 64, 17, 1'b0, 1'b1);
      applyStimulus(0, 64, 34, 1'b0, 1'b0);
      waitDrain(0, 2000, IFG_A);

      // 10/100: each byte held two clocks, IFG doubled.
      speed = 1'b0;
      applyStimulus(0, 64, 51, 1'b0, 1'b1);
      applyStimulus(0, 64, 68, 1'b0, 1'b0);
      waitDrain(0, 2000, IFG_A);

      // Back-to-back 60/1500/60 with one-clock input gaps.
      speed = 1'b1;
      applyStimulus(0, 60, 85, 1'b0, 1'b1);
      applyStimulus(0, 1500, 102, 1'b0, 1'b0);
      applyStimulus(0, 60, 119, 1'b0, 1'b0);
      waitDrain(0, 5000, IFG_A);

      // Small RAM: reader parked in its long IFG, so 200B + 100B overflow 256 bytes.
      applyStimulus(1, 1, 136, 1'b0, 1'b1);
      applyStimulus(1, 200, 153, 1'b0, 1'b0);
      applyStimulus(1, 100, 170, 1'b1, 1'b0);
      applyStimulus(1, 50, 187, 1'b0, 1'b0);
      waitDrain(1, 4000, IFG_B);
      checkOutput("drops_b", drops[1], expDrops[1]);

      // Length FIFO overflow: 16 small frames queue behind a slow 64B frame, the 17th drops.
      speed = 1'b0;
      peak[0] = 0;
      applyStimulus(0, 64, 204, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) applyStimulus(0, 4, 300 + i, 1'b0, 1'b0);
      applyStimulus(0, 4, 400, 1'b1, 1'b0);
      waitDrain(0, 4000, IFG_A);
      checkOutput("peak_queued", peak[0], 16);
      checkOutput("drops_a", drops[0], expDrops[0]);

      // Reset while one frame is sending and the next is being received.
      speed = 1'b1;
      applyStimulus(0, 100, 221, 1'b0, 1'b1);
      driveBytes(0, 20, 238);
      doReset(2);
      applyStimulus(0, 32, 255, 1'b0, 1'b1);
      waitDrain(0, 2000, IFG_A);
      checkOutput("drops_a_final", drops[0], expDrops[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
